// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: round-robin arbiter and APB master sharing one APB bus
// between NREQ requesters. Each granted request runs as one SETUP + ACCESS
// transfer. The winner then gets a one-cycle req_done pulse with the read data.
// Optional feature macro: APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES
// PREADY-low cycles and reports the abort through req_err.
module apb_bus_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_done,
    output logic [31:0]          req_rdata,
    output logic                 req_err,
    output logic [31:0]          PADDR,
    output logic [31:0]          PWDATA,
    output logic                 PWRITE,
    output logic                 PSEL,
    output logic                 PENABLE,
    input  logic                 PREADY,
    input  logic [31:0]          PRDATA
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     last_grant_reg, last_grant_next;
    logic [31:0]       paddr_reg, paddr_next;
    logic [31:0]       pwdata_reg, pwdata_next;
    logic              pwrite_reg, pwrite_next;
    logic              psel_reg, psel_next;
    logic              penable_reg, penable_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [31:0]       rdata_reg, rdata_next;

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Value the counter holds on the ACCESS cycle whose PREADY-low edge times out.
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0]     count_reg, count_next;
    logic              err_reg, err_next;
`endif

    // Per-requester views of the packed address / write-data buses.
    logic [31:0] addr_slice  [NREQ];
    logic [31:0] wdata_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_slice[gi]  = req_addr[32*gi +: 32];
            assign wdata_slice[gi] = req_wdata[32*gi +: 32];
        end
    endgenerate

    logic          winner_found;
    logic [GW-1:0] winner;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        winner_found = 1'b0;
        winner       = last_grant_reg;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_grant_reg) + k) % NREQ;
            if (!winner_found && req_valid[idx]) begin
                winner_found = 1'b1;
                winner       = GW'(idx);
            end
        end
    end

    // Next-state and registered-output logic for the transfer FSM.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        pwrite_next     = pwrite_reg;
        psel_next       = 1'b0;
        penable_next    = 1'b0;
        done_next       = '0;
        rdata_next      = '0;
`ifdef APB_TIMEOUT_EN
        count_next      = count_reg;
        err_next        = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                // Requests are ignored while the previous completion pulse is out.
                if (winner_found && !(|done_reg)) begin
                    state_next      = SETUP;
                    last_grant_next = winner;
                    paddr_next      = addr_slice[winner];
                    pwdata_next     = wdata_slice[winner];
                    pwrite_next     = req_write[winner];
                    psel_next       = 1'b1;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
`ifdef APB_TIMEOUT_EN
                count_next   = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_next                = IDLE;
                    done_next[last_grant_reg] = 1'b1;
                    rdata_next                = pwrite_reg ? 32'h0 : PRDATA;
                end else begin
`ifdef APB_TIMEOUT_EN
                    if (count_reg == COUNT_LAST) begin
                        state_next                = IDLE;
                        done_next[last_grant_reg] = 1'b1;
                        err_next                  = 1'b1;
                    end else begin
                        count_next   = count_reg + 1'b1;
                        psel_next    = 1'b1;
                        penable_next = 1'b1;
                    end
`else
                    psel_next    = 1'b1;
                    penable_next = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(NREQ - 1);
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            pwrite_reg     <= 1'b0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            done_reg       <= '0;
            rdata_reg      <= '0;
`ifdef APB_TIMEOUT_EN
            count_reg      <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            paddr_reg      <= paddr_next;
            pwdata_reg     <= pwdata_next;
            pwrite_reg     <= pwrite_next;
            psel_reg       <= psel_next;
            penable_reg    <= penable_next;
            done_reg       <= done_next;
            rdata_reg      <= rdata_next;
`ifdef APB_TIMEOUT_EN
            count_reg      <= count_next;
            err_reg        <= err_next;
`endif
        end
    end

    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign PWRITE    = pwrite_reg;
    assign PSEL      = psel_reg;
    assign PENABLE   = penable_reg;
    assign req_done  = done_reg;
    assign req_rdata = rdata_reg;
`ifdef APB_TIMEOUT_EN
    assign req_err   = err_reg;
`else
    assign req_err   = 1'b0;
`endif

endmodule
